// File: rtl/arm_mem_responder.sv
// arm_mem_responder
//   Memory-side responder for the ARM core data bus. Serves one word load or
//   store at a time. An access can go to a word RAM, to the board registers
//   (LED, switches, free-running cycle counter), or it returns an error.
//   A programmable number of wait states stretches every access.
//
// Ports
//   clk, reset        clock; synchronous active-low reset
//   req_valid/ready   request handshake (accepted when both are high)
//   req_write         1 = store, 0 = load
//   req_addr          byte address
//   req_wdata         store data
//   resp_valid        one-cycle response strobe (no backpressure)
//   resp_rdata        load data; 0 for stores and errors; held between responses
//   resp_err          access faulted; qualify with resp_valid
//   led               LED register
//   sw                asynchronous board switches
module arm_mem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned LED_W       = 18,
    parameter int unsigned SW_W        = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [LED_W-1:0] led,
    input  logic [SW_W-1:0]  sw
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [31:0] LED_ADDR = 32'h8000_0000;
    localparam logic [31:0] SW_ADDR  = 32'h8000_0004;
    localparam logic [31:0] CYC_ADDR = 32'h8000_0008;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic            cap_write;
    logic [31:0]     cap_addr;
    logic [31:0]     cap_wdata;
    logic [3:0]      wcnt;
    logic [31:0]     cycles;
    logic [SW_W-1:0] sw_s1, sw_s2;
    logic [31:0]     mem [DEPTH];

    logic            accept;
    logic            do_access;
    logic            aligned;
    logic            hit_ram, hit_led, hit_sw, hit_cyc;
    logic            acc_err;
    logic [AW-1:0]   ram_idx;
    logic [31:0]     rd_data;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (wcnt == 4'd0) state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = (state == IDLE) && req_valid;
    // Gated by reset so a reset landing on the access edge suppresses every write.
    assign do_access = (state == WAIT) && (wcnt == 4'd0) && reset;

    // ---------------- address decode (captured request) ----------------
    assign aligned = (cap_addr[1:0] == 2'b00);
    assign hit_ram = aligned && (cap_addr < 32'(DEPTH * 4));
    assign hit_led = (cap_addr == LED_ADDR);
    assign hit_sw  = (cap_addr == SW_ADDR);
    assign hit_cyc = (cap_addr == CYC_ADDR);
    assign acc_err = !(hit_ram || hit_led || hit_sw || hit_cyc) || (hit_sw && cap_write);
    assign ram_idx = cap_addr[AW+1:2];

    always_comb begin
        rd_data = '0;
        if (hit_ram)      rd_data = mem[ram_idx];
        else if (hit_led) rd_data = 32'(led);
        else if (hit_sw)  rd_data = 32'(sw_s2);
        else if (hit_cyc) rd_data = cycles;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            wcnt       <= '0;
            cycles     <= '0;
            led        <= '0;
            sw_s1      <= '0;
            sw_s2      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            sw_s1 <= sw;
            sw_s2 <= sw_s1;

            if (accept) begin
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
                wcnt      <= 4'(WAIT_STATES);
            end else if (state == WAIT && wcnt != 4'd0) begin
                wcnt <= wcnt - 4'd1;
            end

            // A store to CYCLES overrides that cycle's increment.
            if (do_access && cap_write && hit_cyc) cycles <= cap_wdata;
            else                                   cycles <= cycles + 32'd1;

            if (do_access && cap_write && hit_led) led <= cap_wdata[LED_W-1:0];

            if (do_access) begin
                resp_err   <= acc_err;
                resp_rdata <= (acc_err || cap_write) ? 32'd0 : rd_data;
            end
        end
    end

    // RAM has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (do_access && cap_write && hit_ram) mem[ram_idx] <= cap_wdata;
    end

endmodule

// File: doc/arm_mem_responder.md
# arm_mem_responder

Memory-side responder for the ARM core's data bus. It serves one word-sized load or store at a time over a valid/ready request channel and a one-cycle response pulse. Requests map to a word RAM, a small set of board memory-mapped registers (LEDs, switches, cycle counter), or an error response. A programmable wait-state count lets the core's multicycle and pipelined variants be exercised against a slow memory.

## Interface
- DEPTH, 64: RAM size in 32-bit words; power of two, ≥ 2.
- WAIT_STATES, 0: extra WAIT cycles per access, 0–15.
- LED_W, 18: width of the LED register.
- SW_W, 18: width of the switch input.

- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low: 0 = reset, sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  access faulted; valid only with resp_valid.
- led  out  LED_W  LED register.
- sw  in  SW_W  asynchronous board switches.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - req_valid & req_ready captures req_write, req_addr and req_wdata, loads wcnt = WAIT_STATES and moves to WAIT.
- WAIT:
  - req_ready = 0; request inputs are ignored.
  - While wcnt ≠ 0, decrement wcnt.
  - When wcnt = 0, perform the access on the clock edge and move to RESP.
- RESP:
  - resp_valid = 1 with the registered resp_rdata and resp_err.
  - Move to IDLE unconditionally. The requester must accept the response in this cycle; there is no backpressure.
- Only one request is outstanding at a time. Requests are processed strictly in order. A load issued after a store always sees the stored value.
- Address decode (captured address):
  - addr[1:0] ≠ 0: misaligned, error.
  - addr < DEPTH*4: RAM word at addr[log2(DEPTH)+1:2].
  - 0x8000_0000 LED: read/write. A write loads wdata[LED_W-1:0]. A read returns the value zero-extended.
  - 0x8000_0004 SW: read-only. A read returns the synchronised switch value zero-extended. A write is an error.
  - 0x8000_0008 CYCLES: read/write. This is a free-running 32-bit counter that increments every cycle and wraps 0xFFFF_FFFF→0. A write loads wdata, which takes priority over that cycle's increment. A read returns the counter value in the access cycle.
  - Any other address is an error.
- An error access has no side effects (nothing is written) and returns resp_rdata = 0, resp_err = 1.
- sw passes through a 2-flop synchroniser before it is readable.
- RAM is not cleared by reset; its contents are undefined until written.

## Timing
- Reset (reset = 0 at an edge) gives:
  - state IDLE, req_ready = 1 from the next cycle;
  - resp_valid = 0, resp_rdata = 0, resp_err = 0;
  - led = 0, CYCLES = 0, synchroniser flops = 0.
- Reset mid-operation (in WAIT) abandons the request. No RAM or register write occurs, and no response is issued.
- Request accepted at the edge ending cycle 0:
  - WAIT occupies cycles 1..WAIT_STATES+1.
  - The access is performed at the edge ending cycle WAIT_STATES+1.
  - resp_valid is high in cycle WAIT_STATES+2 only.
  - req_ready returns to 1 in cycle WAIT_STATES+3.
- Latency from accept to response is WAIT_STATES+2 cycles. Maximum throughput is one access per WAIT_STATES+3 cycles.
- A store is visible to any later load. CYCLES read data reflects the counter value before that cycle's increment.
- sw changes are readable 2 cycles after they arrive at the pin, at the earliest.
- resp_rdata and resp_err hold their values outside RESP. Checkers must qualify them with resp_valid.

## Test plan
- Reset and idle: hold reset = 0 for 3 cycles, then release → req_ready = 1, resp_valid = 0, led = 0.
- RAM store/load, WAIT_STATES = 0:
  - Store 0xDEADBEEF to 0x10, then load 0x10 → load resp_rdata = 0xDEADBEEF, resp_err = 0.
  - Store response: resp_rdata = 0.
  - Each resp_valid arrives exactly 2 cycles after its accept.
- Wait states, WAIT_STATES = 3: load 0x0 → resp_valid exactly 5 cycles after accept. req_ready = 0 for cycles 1–5, and a req_valid held during those cycles is not accepted until cycle 6.
- MMIO:
  - Store 0x3_FFFF to 0x8000_0000 → led = 0x3FFFF after the access edge.
  - Drive sw = 0x155 → a load of 0x8000_0004 issued ≥ 3 cycles later returns 0x155.
  - Store 0xFFFF_FFFE to 0x8000_0008, then load it 2 cycles after the store's access edge → the counter has wrapped through 0.
- Errors: load 0x2, load 0x4000_0000, and store to 0x8000_0004 → each gives resp_err = 1, resp_rdata = 0, and RAM, led and CYCLES are unchanged.
- Reset mid-operation, WAIT_STATES = 3: accept a store to 0x20, assert reset in cycle 2 → no resp_valid. A later load of 0x20 does not return the aborted data (preload 0x20 with 0x1234 first; the load returns 0x1234).
